// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder that time-shares one external 4-bit CLA slice, one nibble per cycle, LSB first.
// Optional macro OVERFLOW_FLAG_EN adds a registered two's-complement overflow output (ovf).
module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_s,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef OVERFLOW_FLAG_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if ((WIDTH < 4) || (WIDTH % 4 != 0)) begin : g_bad_width
      $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W+1:0] base;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic             last_nib;

  assign base      = {idx, 2'b00};
  assign last_nib  = (idx == LAST_IDX);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and neither depends on the other side's valid/ready.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    cla_a      = 4'h0;
    cla_b      = 4'h0;
    cla_cin    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        cla_a   = a_reg[base +: 4];
        cla_b   = b_reg[base +: 4];
        cla_cin = carry;
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[base +: 4] <= cla_s;
          carry          <= cla_cout;
          if (last_nib) begin
            idx  <= '0;
            cout <= cla_cout;
`ifdef OVERFLOW_FLAG_EN
            // The top nibble's sum is still on cla_s, so its MSB is the final sum MSB.
            ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (cla_s[3] != a_reg[WIDTH-1]);
`endif
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) idx <= '0;
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed bench for cla_nibble_sequencer (WIDTH=16) driving a behavioural 4-bit CLA on the cla_* ports.
module tb_cla_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin;
  logic        cla_cin, cla_cout, out_valid, out_ready, cout;
  logic [15:0] a, b, sum;
  logic [3:0]  cla_a, cla_b, cla_s;
  logic [1:0]  dbg_state;
`ifdef OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  logic [16:0] exp_q[$];
  logic [16:0] res_q[$];
  int          rc_q[$];
  int          n_acc, n_res;
  logic        acc;

  cla_nibble_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_s(cla_s), .cla_cout(cla_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout),
`ifdef OVERFLOW_FLAG_EN
    .ovf(ovf),
`endif
    .dbg_state(dbg_state)
  );

  // 4-bit carry-lookahead slice
  logic [3:0] g, p;
  logic [4:0] c;
  always_comb begin
    g    = cla_a & cla_b;
    p    = cla_a ^ cla_b;
    c[0] = cla_cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    cla_s    = p ^ c[3:0];
    cla_cout = c[4];
  end

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    tests++;
    assert (obs === expd) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic start_add(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    step();
    in_valid = 1'b0;
    a = 16'h0;
    b = 16'h0;
    cin = 1'b0;
    check({tag, "_state_run"}, 32'(dbg_state), 32'd1);
    check({tag, "_cla_a0"}, 32'(cla_a), 32'(ta[3:0]));
    check({tag, "_cla_cin0"}, 32'(cla_cin), 32'(tc));
  endtask

  task automatic run_to_done(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_run_out_valid"}, 32'(out_valid), 32'd0);
      step();
    end
    check({tag, "_done_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic do_add(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input logic [15:0] esum, input logic ecout, input logic eovf, input string tag);
    start_add(ta, tb, tc, tag);
    run_to_done(tag);
    check({tag, "_sum"}, 32'(sum), 32'(esum));
    check({tag, "_cout"}, 32'(cout), 32'(ecout));
`ifdef OVERFLOW_FLAG_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("[TB] %s overflow expectation unknown", tag);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_back_idle"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 16'h0;
    b = 16'h0;
    cin = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_cla_a", 32'(cla_a), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif

    // basic add and full carry ripple
    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "t1");
    do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "t2a");
    do_add(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "t2b");

    // backpressure in DONE with a competing request
    start_add(16'h1234, 16'h4321, 1'b0, "t3");
    run_to_done("t3");
    in_valid = 1'b1;
    a = 16'h0001;
    b = 16'h0001;
    cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_sum", 32'(sum), 32'h5555);
      check("t3_hold_out_valid", 32'(out_valid), 32'd1);
      check("t3_hold_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_post_hs_state", 32'(dbg_state), 32'd0);
    check("t3_post_hs_in_ready", 32'(in_ready), 32'd1);
    check("t3_post_hs_out_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check("t3_next_accepted", 32'(dbg_state), 32'd1);
    run_to_done("t3b");
    check("t3b_sum", 32'(sum), 32'h0002);
    check("t3b_cout", 32'(cout), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset while RUN is at nibble 2
    start_add(16'h1234, 16'h4321, 1'b0, "t4");
    step();
    step();
    check("t4_idx2_cla_a", 32'(cla_a), 32'h2);
    check("t4_idx2_cla_b", 32'(cla_b), 32'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_state", 32'(dbg_state), 32'd0);
    check("t4_sum", 32'(sum), 32'd0);
    check("t4_cout", 32'(cout), 32'd0);
    check("t4_out_valid", 32'(out_valid), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    do_add(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, "t4b");

    // back-to-back with out_ready held high
    exp_q.push_back({1'b0, 16'hBCDE});
    exp_q.push_back({1'b1, 16'h0000});
    in_valid = 1'b1;
    a = 16'hABCD;
    b = 16'h1111;
    cin = 1'b0;
    out_ready = 1'b1;
    n_acc = 0;
    n_res = 0;
    for (int i = 0; i < 40 && n_res < 2; i++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        res_q.push_back({cout, sum});
        rc_q.push_back(cyc);
        n_res++;
      end
      step();
      if (acc) begin
        n_acc++;
        if (n_acc == 1) begin
          a = 16'h8000;
          b = 16'h8000;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("t5_result_count", 32'(n_res), 32'd2);
    for (int i = 0; i < n_res && i < 2; i++) begin
      check("t5_result", 32'(res_q[i]), 32'(exp_q[i]));
    end
    if (n_res == 2) check("t5_spacing", 32'(rc_q[1] - rc_q[0]), 32'd6);
    check("t5_final_state", 32'(dbg_state), 32'd0);

`ifdef OVERFLOW_FLAG_EN
    do_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "t6a");
    do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "t6b");
    do_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "t6c");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
